// File: rtl/fc_serializer_if.sv
// Vector-in / word-out bus of fc_serializer: upstream valid/ready vector side plus
// the writer half of the downstream FIFO (data/wen/full).
interface fc_serializer_if #(
    parameter int WORD_SIZE    = 16,
    parameter int LAYER_HEIGHT = 2
);
    logic                                   valid_i;
    logic                                   ready_o;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_i;
    logic [WORD_SIZE-1:0]                   data_o;
    logic                                   wen_o;
    logic                                   full_i;
    logic                                   busy_o;

    // slave: the serializer itself; master: upstream producer plus downstream FIFO
    modport slave  (input  valid_i, data_i, full_i,
                    output ready_o, data_o, wen_o, busy_o);
    modport master (output valid_i, data_i, full_i,
                    input  ready_o, data_o, wen_o, busy_o);
endinterface

// File: rtl/fc_serializer.sv
// Captures one LAYER_HEIGHT-word vector and writes it word-by-word into a FIFO.
// Optional macro FC_SERIALIZER_RELU_EN clamps negative words to zero at capture.
module fc_serializer #(
    parameter int WORD_SIZE    = 16,
    parameter int LAYER_HEIGHT = 2
) (
    input logic            clk_i,
    input logic            reset_n_i,
    fc_serializer_if.slave bus
);
    localparam int IDX_W = (LAYER_HEIGHT > 1) ? $clog2(LAYER_HEIGHT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAYER_HEIGHT - 1);

    typedef enum logic {eIDLE, eSEND} state_e;

    state_e                                 ps_q, ns_d;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic                                   ready, wen, busy, load;
    logic [WORD_SIZE-1:0]                   dout;

    function automatic logic [WORD_SIZE-1:0] capture_word(input logic [WORD_SIZE-1:0] w);
`ifdef FC_SERIALIZER_RELU_EN
        return w[WORD_SIZE-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    always_comb begin
        ns_d  = ps_q;
        buf_d = buf_q;
        idx_d = idx_q;
        ready = 1'b0;
        wen   = 1'b0;
        busy  = 1'b0;
        load  = 1'b0;
        dout  = '0;
        case (ps_q)
            eIDLE: begin
                ready = 1'b1;
                if (bus.valid_i) begin
                    load = 1'b1;
                    ns_d = eSEND;
                end
            end
            eSEND: begin
                busy = 1'b1;
                dout = buf_q[idx_q];
                wen  = !bus.full_i;
                if (wen) begin
                    if (idx_q == LAST_IDX) begin
                        // last word leaves this cycle, so a new vector may land in buf now
                        ready = 1'b1;
                        if (bus.valid_i) load = 1'b1;
                        else             ns_d = eIDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: ns_d = eIDLE;
        endcase
        if (load) begin
            idx_d = '0;
            for (int i = 0; i < LAYER_HEIGHT; i++) buf_d[i] = capture_word(bus.data_i[i]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ps_q  <= eIDLE;
            idx_q <= '0;
            buf_q <= '0;
        end else begin
            ps_q  <= ns_d;
            idx_q <= idx_d;
            buf_q <= buf_d;
        end
    end

    assign bus.ready_o = ready;
    assign bus.wen_o   = wen;
    assign bus.busy_o  = busy;
    assign bus.data_o  = dout;
endmodule
